// File: rtl/nic.sv
`default_nettype none
// ============================================================================
// Module   : nic
// Purpose  : Network interface between a processor register port and a
//            router channel pair. One-entry input buffer (router -> processor)
//            and one-entry output buffer (processor -> router). The two
//            buffers operate independently and can be active in the same
//            cycle.
//
// Ports    : clk          system clock, rising-edge active
//            reset        synchronous active-high reset
//            addr         register select: 00 in_buf, 01 in status,
//                         10 out_buf, 11 out status
//            d_in         processor write data
//            d_out        processor read data (combinational)
//            nicEn        processor access enable
//            nicWrEn      1 = write, 0 = read (qualified by nicEn)
//            net_si       router send request on the input channel
//            net_ri       NIC ready to accept on the input channel
//            net_di       packet from the router
//            net_so       NIC send on the output channel
//            net_ro       router ready to accept from the NIC
//            net_do       packet to the router
//            net_polarity router even/odd phase, matched against VC bit
//
// Revision : 1.0  initial release
// ============================================================================
module nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:1]  addr,
    input  logic [0:63] d_in,
    output logic [0:63] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [0:63] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [0:63] net_do,
    input  logic        net_polarity
);

    localparam logic [0:1] C_ADDR_IN_BUF  = 2'b00;
    localparam logic [0:1] C_ADDR_IN_STAT = 2'b01;
    localparam logic [0:1] C_ADDR_OUT_BUF = 2'b10;
    localparam logic [0:1] C_ADDR_OUT_STAT = 2'b11;

    logic [0:63] r_in_buf;
    logic        r_in_full;
    logic [0:63] r_out_buf;
    logic        r_out_full;

    logic        w_rd;
    logic        w_wr;
    logic        w_fill;
    logic        w_drain;
    logic        w_load_out;
    logic        w_send;

    assign w_rd = nicEn & ~nicWrEn;
    assign w_wr = nicEn &  nicWrEn;

    // Ready only when empty, so a fill and a drain can never share a cycle.
    assign net_ri  = ~r_in_full;
    assign w_fill  = net_si & net_ri;
    assign w_drain = w_rd & (addr == C_ADDR_IN_BUF) & r_in_full;

    // out_buf[0] is the packet VC bit; it must match the router phase.
    assign w_send     = r_out_full & net_ro & (r_out_buf[0] == net_polarity);
    // A write while full is dropped, even in the cycle the buffer empties.
    assign w_load_out = w_wr & (addr == C_ADDR_OUT_BUF) & ~r_out_full;

    assign net_so = w_send;
    assign net_do = r_out_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_buf   <= '0;
            r_in_full  <= 1'b0;
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
        end else begin
            if (w_fill) begin
                r_in_buf  <= net_di;
                r_in_full <= 1'b1;
            end else if (w_drain) begin
                r_in_full <= 1'b0;
            end

            if (w_send) begin
                r_out_full <= 1'b0;
            end else if (w_load_out) begin
                r_out_buf  <= d_in;
                r_out_full <= 1'b1;
            end
        end
    end

    always_comb begin
        d_out = '0;
        if (w_rd) begin
            case (addr)
                C_ADDR_IN_BUF:   d_out = r_in_buf;
                C_ADDR_IN_STAT:  d_out = {63'b0, r_in_full};
                C_ADDR_OUT_STAT: d_out = {63'b0, r_out_full};
                default:         d_out = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nic.sv
`default_nettype none
// ============================================================================
// Module   : tb_nic
// Purpose  : Directed testbench for nic. Stimulus pushes expected
//            observations into a check queue and expected output packets into
//            a send queue; a monitor on the falling edge pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_nic;

    localparam int SEL_DOUT = 0;
    localparam int SEL_RI   = 1;
    localparam int SEL_SO   = 2;
    localparam int SEL_DO   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [63:0] out_q[$];
    int          tests = 0;
    int          fails = 0;

    nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor: evaluates queued expectations and every output transfer.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] act;
        logic [63:0] e;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.sel)
                SEL_DOUT: act = d_out;
                SEL_RI:   act = {63'b0, net_ri};
                SEL_SO:   act = {63'b0, net_so};
                default:  act = net_do;
            endcase
            tests++;
            if (act !== c.exp) begin
                fails++;
                $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
            end
        end
        if (net_so === 1'b1) begin
            tests++;
            if (out_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_send: got net_do %h, expected no send", net_do);
            end else begin
                e = out_q.pop_front();
                if (net_do !== e) begin
                    fails++;
                    $display("FAIL send_data: got %h, expected %h", net_do, e);
                end
            end
            tests++;
            if (net_ro !== 1'b1 || net_polarity !== net_do[0]) begin
                fails++;
                $display("FAIL send_gate: got ro=%b pol=%b vc=%b, expected ro=1 pol=vc",
                         net_ro, net_polarity, net_do[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic idle_proc();
        nicEn   = 1'b0;
        nicWrEn = 1'b0;
        addr    = 2'b00;
        d_in    = '0;
    endtask

    task automatic rd(input logic [0:1] a);
        nicEn   = 1'b1;
        nicWrEn = 1'b0;
        addr    = a;
    endtask

    task automatic wr(input logic [0:1] a, input logic [63:0] v);
        nicEn   = 1'b1;
        nicWrEn = 1'b1;
        addr    = a;
        d_in    = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_proc();
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        step();
        expect_val("rst_ri", SEL_RI, 64'd1);
        expect_val("rst_so", SEL_SO, 64'd0);
        expect_val("rst_do", SEL_DO, 64'd0);
        expect_val("rst_dout", SEL_DOUT, 64'd0);
        step();
        reset = 1'b0;
        step();

        // Input path
        net_si = 1'b1; net_di = 64'hA5A5_0000_0000_0001;
        expect_val("in_ri_before", SEL_RI, 64'd1);
        step();
        net_si = 1'b0;
        expect_val("in_ri_full", SEL_RI, 64'd0);
        rd(2'b01);
        expect_val("in_stat_full", SEL_DOUT, 64'd1);
        step();
        rd(2'b00);
        expect_val("in_data", SEL_DOUT, 64'hA5A5_0000_0000_0001);
        step();
        idle_proc();
        expect_val("in_ri_drained", SEL_RI, 64'd1);
        step();
        rd(2'b01);
        expect_val("in_stat_empty", SEL_DOUT, 64'd0);
        step();
        rd(2'b00);
        expect_val("in_stale", SEL_DOUT, 64'hA5A5_0000_0000_0001);
        step();
        idle_proc();
        expect_val("in_stale_ri", SEL_RI, 64'd1);

        // Input backpressure
        net_si = 1'b1; net_di = 64'h1111_1111_1111_1111;
        step();
        net_di = 64'h2222_2222_2222_2222;
        expect_val("bp_ri_0", SEL_RI, 64'd0);
        wr(2'b00, 64'hDEAD_BEEF_DEAD_BEEF);
        expect_val("wr_gates_dout", SEL_DOUT, 64'd0);
        step();
        net_si = 1'b0;
        expect_val("bp_ri_1", SEL_RI, 64'd0);
        rd(2'b00);
        expect_val("bp_first_word", SEL_DOUT, 64'h1111_1111_1111_1111);
        step();
        idle_proc();
        expect_val("bp_ri_after", SEL_RI, 64'd1);
        step();

        // Output path
        net_polarity = 1'b1; net_ro = 1'b1;
        wr(2'b10, 64'h8000_0000_0000_00FF);
        out_q.push_back(64'h8000_0000_0000_00FF);
        step();
        rd(2'b11);
        expect_val("out_so", SEL_SO, 64'd1);
        expect_val("out_stat_full", SEL_DOUT, 64'd1);
        step();
        expect_val("out_stat_clr", SEL_DOUT, 64'd0);
        expect_val("out_so_clr", SEL_SO, 64'd0);
        step();

        // Polarity / ready hold, VC bit 0
        net_ro = 1'b0;
        wr(2'b10, 64'h0000_0000_0000_1234);
        out_q.push_back(64'h0000_0000_0000_1234);
        step();
        idle_proc();
        net_polarity = 1'b0;
        expect_val("hold_so_a", SEL_SO, 64'd0);
        step();
        net_polarity = 1'b1;
        expect_val("hold_so_b", SEL_SO, 64'd0);
        step();
        net_polarity = 1'b0;
        expect_val("hold_so_c", SEL_SO, 64'd0);
        step();
        net_ro = 1'b1; net_polarity = 1'b1;
        expect_val("hold_so_pol", SEL_SO, 64'd0);
        step();
        net_polarity = 1'b0;
        expect_val("hold_so_go", SEL_SO, 64'd1);
        step();
        net_ro = 1'b0;
        rd(2'b11);
        expect_val("hold_stat_clr", SEL_DOUT, 64'd0);
        step();

        // Write while full is dropped, also in the draining cycle
        net_polarity = 1'b1;
        wr(2'b10, 64'h8000_0000_0000_0AAA);
        out_q.push_back(64'h8000_0000_0000_0AAA);
        step();
        net_ro = 1'b1;
        wr(2'b10, 64'h8000_0000_0000_0BBB);
        expect_val("drop_so", SEL_SO, 64'd1);
        step();
        rd(2'b11);
        expect_val("drop_stat", SEL_DOUT, 64'd0);
        step();
        wr(2'b11, 64'h0000_0000_0000_0001);
        step();
        rd(2'b11);
        expect_val("wr11_ignored", SEL_DOUT, 64'd0);
        step();

        // Reset mid-operation with both buffers full
        net_ro = 1'b0; net_polarity = 1'b0;
        net_si = 1'b1; net_di = 64'hCAFE_0000_0000_0001;
        wr(2'b10, 64'h8000_0000_0000_0777);
        out_q.push_back(64'h8000_0000_0000_0777);
        step();
        net_si = 1'b0;
        rd(2'b11);
        expect_val("pre_rst_ri", SEL_RI, 64'd0);
        expect_val("pre_rst_out", SEL_DOUT, 64'd1);
        step();
        reset = 1'b1;
        idle_proc();
        step();
        reset = 1'b0;
        out_q.delete();
        expect_val("mid_rst_ri", SEL_RI, 64'd1);
        expect_val("mid_rst_so", SEL_SO, 64'd0);
        expect_val("mid_rst_do", SEL_DO, 64'd0);
        expect_val("mid_rst_dout", SEL_DOUT, 64'd0);
        step();
        net_ro = 1'b1;
        rd(2'b01);
        expect_val("mid_rst_in_stat", SEL_DOUT, 64'd0);
        step();
        rd(2'b11);
        expect_val("mid_rst_out_stat", SEL_DOUT, 64'd0);
        step();
        rd(2'b00);
        expect_val("mid_rst_in_buf", SEL_DOUT, 64'd0);
        step();
        idle_proc();
        step();
        step();

        tests++;
        if (out_q.size() != 0) begin
            fails++;
            $display("FAIL pending_sends: got %0d outstanding, expected 0", out_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
